// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole controller: FSM state encoding,
// default geometry and the width of the hit/escape/miss counters.
package mole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int DEF_NUM_HOLES  = 16;
    localparam int DEF_MOLE_LIFE  = 4;
    localparam int DEF_MAX_ACTIVE = 3;

    // Width of score / escape_cnt / miss_cnt.
    localparam int CNT_W  = 8;
    // Width of the per-hole life counters.
    localparam int LIFE_W = 4;

endpackage

// File: rtl/mole_ctrl_sat_counter.sv
// sat_counter: combinational saturating adder for the game counters.
// Adds an increment of 0..2**INC_W-1 to an 8-bit value. In binary mode it
// saturates at 8'hFF; in BCD mode the value is two digits {tens,ones} and
// saturates at 8'h99. The caller owns the register.
module sat_counter
    import mole_pkg::*;
#(
    parameter int INC_W = 5,
    parameter bit BCD   = 1'b0
) (
    input  logic [CNT_W-1:0] val,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] res
);

    localparam int SUM_W = CNT_W + INC_W;

    logic [SUM_W-1:0] bin_sum;
    logic [SUM_W-1:0] bcd_bin;
    logic [SUM_W-1:0] bcd_sum;

    // Add in binary; for BCD, convert to binary first, add, clip and convert back.
    always_comb begin
        bin_sum = SUM_W'(val) + SUM_W'(inc);
        bcd_bin = SUM_W'(val[7:4]) * SUM_W'(10) + SUM_W'(val[3:0]);
        bcd_sum = bcd_bin + SUM_W'(inc);
        if (BCD) begin
            if (bcd_sum > SUM_W'(99)) begin
                res = 8'h99;
            end else begin
                res = {4'(bcd_sum / SUM_W'(10)), 4'(bcd_sum % SUM_W'(10))};
            end
        end else begin
            if (bin_sum > SUM_W'(255)) begin
                res = 8'hFF;
            end else begin
                res = bin_sum[7:0];
            end
        end
    end

endmodule

// File: rtl/mole_ctrl.sv
// mole_ctrl: whack-a-mole game controller.
// IDLE waits for a gamestart rising edge, ARM clears the game for one cycle,
// RUN spawns moles on refreshSig, ages them, and scores button rising edges.
// All outputs are registered; a hit clears its mole and updates score one
// cycle after the edge. dbg_state exposes the FSM state for observation.
// Optional build macro MOLE_BCD_SCORE_EN: score is kept as two BCD digits
// (saturating at 8'h99) instead of 8-bit binary (saturating at 8'hFF).
module mole_ctrl
    import mole_pkg::*;
#(
    parameter int NUM_HOLES  = DEF_NUM_HOLES,
    parameter int MOLE_LIFE  = DEF_MOLE_LIFE,
    parameter int MAX_ACTIVE = DEF_MAX_ACTIVE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gamestart,
    input  logic                 refreshSig,
    input  logic [31:0]          randout,
    input  logic [NUM_HOLES-1:0] hit_btn,
    output logic [NUM_HOLES-1:0] mole,
    output logic [CNT_W-1:0]     score,
    output logic [CNT_W-1:0]     escape_cnt,
    output logic [CNT_W-1:0]     miss_cnt,
    output logic                 hit_pulse,
    output logic [1:0]           dbg_state
);

    localparam int HOLE_W = $clog2(NUM_HOLES);
    localparam int INC_W  = $clog2(NUM_HOLES + 1);

`ifdef MOLE_BCD_SCORE_EN
    localparam bit SCORE_BCD = 1'b1;
`else
    localparam bit SCORE_BCD = 1'b0;
`endif

    state_t               state_q, state_d;
    logic                 gs_q, gs_d;
    logic [NUM_HOLES-1:0] btn_q, btn_d;
    logic [NUM_HOLES-1:0] mole_q, mole_d;
    logic [LIFE_W-1:0]    life_q [NUM_HOLES];
    logic [LIFE_W-1:0]    life_d [NUM_HOLES];
    logic [CNT_W-1:0]     score_q, score_d;
    logic [CNT_W-1:0]     esc_q, esc_d;
    logic [CNT_W-1:0]     miss_q, miss_d;
    logic                 hit_pulse_q, hit_pulse_d;

    logic                 run_act;
    logic [NUM_HOLES-1:0] edge_v;
    logic [NUM_HOLES-1:0] hit_v;
    logic [NUM_HOLES-1:0] miss_v;
    logic [NUM_HOLES-1:0] exp_v;
    logic [NUM_HOLES-1:0] spawn_v;
    logic [HOLE_W-1:0]    cand_a, cand_b;
    logic [INC_W-1:0]     active_cnt, n_hit, n_miss, n_esc;
    logic [CNT_W-1:0]     score_nx, esc_nx, miss_nx;
    logic                 unused_rand;

    function automatic logic [INC_W-1:0] popcnt(input logic [NUM_HOLES-1:0] v);
        logic [INC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            c = c + INC_W'(v[i]);
        end
        return c;
    endfunction

    // Game events only happen in RUN while gamestart is still high; the cycle
    // gamestart drops is spent leaving RUN with all game state held.
    assign run_act = (state_q == ST_RUN) && gamestart;
    assign edge_v  = hit_btn & ~btn_q;
    assign hit_v   = run_act ? (edge_v & mole_q) : '0;
    assign miss_v  = run_act ? (edge_v & ~mole_q) : '0;

    assign cand_a      = randout[HOLE_W-1:0];
    assign cand_b      = randout[2*HOLE_W-1:HOLE_W];
    assign unused_rand = ^randout[31:2*HOLE_W];

    assign active_cnt = popcnt(mole_q);
    assign n_hit      = popcnt(hit_v);
    assign n_miss     = popcnt(miss_v);
    assign n_esc      = popcnt(exp_v);

    // A mole expires when a refresh takes its life to zero, unless it was hit.
    always_comb begin
        exp_v = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            exp_v[i] = run_act && refreshSig && mole_q[i] && !hit_v[i]
                       && (life_q[i] == LIFE_W'(1));
        end
    end

    // Spawn at A, else B; occupancy is the registered mole map, so holes
    // being hit or expiring this cycle still block the spawn.
    always_comb begin
        spawn_v = '0;
        if (run_act && refreshSig && (active_cnt < INC_W'(MAX_ACTIVE))) begin
            if (!mole_q[cand_a]) begin
                spawn_v[cand_a] = 1'b1;
            end else if (!mole_q[cand_b]) begin
                spawn_v[cand_b] = 1'b1;
            end
        end
    end

    sat_counter #(.INC_W(INC_W), .BCD(SCORE_BCD)) u_score_sat (
        .val (score_q),
        .inc (n_hit),
        .res (score_nx)
    );

    sat_counter #(.INC_W(INC_W), .BCD(1'b0)) u_esc_sat (
        .val (esc_q),
        .inc (n_esc),
        .res (esc_nx)
    );

    sat_counter #(.INC_W(INC_W), .BCD(1'b0)) u_miss_sat (
        .val (miss_q),
        .inc (n_miss),
        .res (miss_nx)
    );

    // Next-state logic for the FSM, mole map, life counters and counters.
    always_comb begin
        state_d     = state_q;
        gs_d        = gamestart;
        btn_d       = hit_btn;
        mole_d      = mole_q;
        life_d      = life_q;
        score_d     = score_q;
        esc_d       = esc_q;
        miss_d      = miss_q;
        hit_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mole_d = '0;
                for (int i = 0; i < NUM_HOLES; i++) begin
                    life_d[i] = '0;
                end
                if (gamestart && !gs_q) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                mole_d  = '0;
                score_d = '0;
                esc_d   = '0;
                miss_d  = '0;
                for (int i = 0; i < NUM_HOLES; i++) begin
                    life_d[i] = '0;
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!gamestart) begin
                    state_d = ST_IDLE;
                end else begin
                    for (int i = 0; i < NUM_HOLES; i++) begin
                        if (hit_v[i] || exp_v[i]) begin
                            mole_d[i] = 1'b0;
                            life_d[i] = '0;
                        end else if (spawn_v[i]) begin
                            mole_d[i] = 1'b1;
                            life_d[i] = LIFE_W'(MOLE_LIFE);
                        end else if (refreshSig && mole_q[i]) begin
                            life_d[i] = life_q[i] - LIFE_W'(1);
                        end
                    end
                    score_d     = score_nx;
                    esc_d       = esc_nx;
                    miss_d      = miss_nx;
                    hit_pulse_d = |hit_v;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gs_q        <= 1'b0;
            btn_q       <= '0;
            mole_q      <= '0;
            score_q     <= '0;
            esc_q       <= '0;
            miss_q      <= '0;
            hit_pulse_q <= 1'b0;
            for (int i = 0; i < NUM_HOLES; i++) begin
                life_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            gs_q        <= gs_d;
            btn_q       <= btn_d;
            mole_q      <= mole_d;
            score_q     <= score_d;
            esc_q       <= esc_d;
            miss_q      <= miss_d;
            hit_pulse_q <= hit_pulse_d;
            life_q      <= life_d;
        end
    end

    assign mole       = mole_q;
    assign score      = score_q;
    assign escape_cnt = esc_q;
    assign miss_cnt   = miss_q;
    assign hit_pulse  = hit_pulse_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mole_ctrl.sv
// Bench for mole_ctrl: directed scenarios followed by a random phase, every
// cycle compared against a game-rule reference model. Honours
// MOLE_BCD_SCORE_EN for the expected score format.
module tb_mole_ctrl;

    localparam int N  = 16;
    localparam int ML = 4;
    localparam int MA = 3;
    localparam int LN = $clog2(N);

`ifdef MOLE_BCD_SCORE_EN
    localparam bit         BCD       = 1'b1;
    localparam int         SCORE_MAX = 99;
    localparam logic [7:0] SAT_SCORE = 8'h99;
`else
    localparam bit         BCD       = 1'b0;
    localparam int         SCORE_MAX = 255;
    localparam logic [7:0] SAT_SCORE = 8'hFF;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         gamestart;
    logic         refreshSig;
    logic [31:0]  randout;
    logic [N-1:0] hit_btn;
    logic [N-1:0] mole;
    logic [7:0]   score;
    logic [7:0]   escape_cnt;
    logic [7:0]   miss_cnt;
    logic         hit_pulse;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    mole_ctrl #(.NUM_HOLES(N), .MOLE_LIFE(ML), .MAX_ACTIVE(MA)) dut (
        .clk        (clk),
        .rst        (rst),
        .gamestart  (gamestart),
        .refreshSig (refreshSig),
        .randout    (randout),
        .hit_btn    (hit_btn),
        .mole       (mole),
        .score      (score),
        .escape_cnt (escape_cnt),
        .miss_cnt   (miss_cnt),
        .hit_pulse  (hit_pulse),
        .dbg_state  (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Game phase: "idle", "arm", "run".
    string        m_phase = "idle";
    bit           m_up   [N];
    int           m_life [N];
    int           m_score, m_esc, m_miss;
    bit           m_pulse;
    bit           m_prev_gs;
    logic [N-1:0] m_prev_btn;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_up[i]   = 1'b0;
            m_life[i] = 0;
        end
    endtask

    task automatic model_step();
        bit old_up [N];
        int hits, misses, escs, active, a, b;
        hits = 0; misses = 0; escs = 0; active = 0;
        if (rst) begin
            model_clear();
            m_phase = "idle";
            m_score = 0; m_esc = 0; m_miss = 0; m_pulse = 0;
            m_prev_gs = 0; m_prev_btn = '0;
            return;
        end
        old_up  = m_up;
        m_pulse = 1'b0;
        if (m_phase == "idle") begin
            model_clear();
            if (gamestart && !m_prev_gs) m_phase = "arm";
        end else if (m_phase == "arm") begin
            model_clear();
            m_score = 0; m_esc = 0; m_miss = 0;
            m_phase = "run";
        end else if (!gamestart) begin
            m_phase = "idle";
        end else begin
            for (int i = 0; i < N; i++) begin
                if (hit_btn[i] && !m_prev_btn[i]) begin
                    if (old_up[i]) begin
                        hits++;
                        m_up[i]   = 1'b0;
                        m_life[i] = 0;
                    end else begin
                        misses++;
                    end
                end
            end
            if (refreshSig) begin
                for (int i = 0; i < N; i++) begin
                    if (old_up[i] && m_up[i]) begin
                        m_life[i]--;
                        if (m_life[i] == 0) begin
                            m_up[i] = 1'b0;
                            escs++;
                        end
                    end
                    active += int'(old_up[i]);
                end
                if (active < MA) begin
                    a = int'(randout) & (N - 1);
                    b = (int'(randout) >> LN) & (N - 1);
                    if (!old_up[a]) begin
                        m_up[a] = 1'b1; m_life[a] = ML;
                    end else if (!old_up[b]) begin
                        m_up[b] = 1'b1; m_life[b] = ML;
                    end
                end
            end
            m_score = sat(m_score + hits, SCORE_MAX);
            m_esc   = sat(m_esc + escs, 255);
            m_miss  = sat(m_miss + misses, 255);
            m_pulse = (hits > 0);
        end
        m_prev_gs  = gamestart;
        m_prev_btn = hit_btn;
    endtask

    function automatic logic [7:0] exp_score();
        if (BCD) return 8'(((m_score / 10) << 4) | (m_score % 10));
        return 8'(m_score);
    endfunction

    function automatic logic [N-1:0] exp_mole();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_up[i];
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mole"},   32'(mole),       32'(exp_mole()));
        check({tag, ".score"},  32'(score),      32'(exp_score()));
        check({tag, ".escape"}, 32'(escape_cnt), 32'(m_esc));
        check({tag, ".miss"},   32'(miss_cnt),   32'(m_miss));
        check({tag, ".pulse"},  32'(hit_pulse),  32'(m_pulse));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic refresh(input logic [31:0] r, input string tag);
        refreshSig = 1'b1;
        randout    = r;
        tick(tag);
        refreshSig = 1'b0;
    endtask

    task automatic new_game(input string tag);
        rst       = 1'b1;
        gamestart = 1'b0;
        hit_btn   = '0;
        tick({tag, ".rst"});
        rst       = 1'b0;
        gamestart = 1'b1;
        tick({tag, ".idle"});
        tick({tag, ".arm"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        gamestart  = 1'b0;
        refreshSig = 1'b0;
        randout    = '0;
        hit_btn    = '0;
        m_score = 0; m_esc = 0; m_miss = 0; m_pulse = 0;
        m_prev_gs = 0; m_prev_btn = '0;
        model_clear();

        // Reset state.
        tick("reset0");
        tick("reset1");
        check("reset.mole",  32'(mole),      32'h0);
        check("reset.score", 32'(score),     32'h0);
        check("reset.state", 32'(dbg_state), 32'h0);

        // Spawn at A, then at B when A is taken.
        new_game("g1");
        refresh(32'h0000_0053, "spawnA");
        check("spawnA.direct", 32'(mole), 32'h0008);
        refresh(32'h0000_0053, "spawnB");
        check("spawnB.direct", 32'(mole), 32'h0028);
        // Two simultaneous hits score two.
        hit_btn = 16'h0028;
        tick("dual_hit");
        check("dual_hit.direct", 32'(mole), 32'h0000);
        hit_btn = '0;
        tick("dual_rel");

        // Mole at hole 3 ages out after MOLE_LIFE refreshes.
        new_game("g2");
        refresh(32'h0000_0033, "exp.spawn");
        for (int i = 0; i < ML; i++) refresh(32'h0000_0033, "exp.age");
        check("exp.mole3",  32'(mole[3]),    32'h0);
        check("exp.escape", 32'(escape_cnt), 32'h1);

        // Hit in the same cycle as the final expiry: hit wins.
        new_game("g3");
        refresh(32'h0000_0033, "hx.spawn");
        for (int i = 0; i < ML - 1; i++) refresh(32'h0000_0033, "hx.age");
        hit_btn[3] = 1'b1;
        refresh(32'h0000_0033, "hx.hit");
        check("hx.score",  32'(score),      32'h1);
        check("hx.escape", 32'(escape_cnt), 32'h0);
        check("hx.pulse",  32'(hit_pulse),  32'h1);
        tick("hx.after");
        check("hx.pulse_end", 32'(hit_pulse), 32'h0);
        hit_btn = '0;
        tick("hx.rel");

        // Held button on an empty hole counts one miss.
        hit_btn[7] = 1'b1;
        for (int i = 0; i < 11; i++) tick("hold7");
        check("hold7.miss", 32'(miss_cnt), 32'h1);
        hit_btn = '0;
        tick("hold7.rel");

        // Reset mid-RUN with score 5 and moles 0 and 4.
        new_game("g4");
        for (int k = 0; k < 5; k++) begin
            refresh(32'h0000_0011, "s5.spawn");
            hit_btn[1] = 1'b1;
            tick("s5.hit");
            hit_btn[1] = 1'b0;
            tick("s5.rel");
        end
        refresh(32'h0000_0000, "s5.m0");
        refresh(32'h0000_0044, "s5.m4");
        check("s5.score", 32'(score), 32'h05);
        check("s5.mole",  32'(mole),  32'h0011);
        rst = 1'b1;
        tick("midrst");
        check("midrst.mole",  32'(mole),       32'h0);
        check("midrst.score", 32'(score),      32'h0);
        check("midrst.state", 32'(dbg_state),  32'h0);
        check("midrst.pulse", 32'(hit_pulse),  32'h0);
        rst = 1'b0;

        // Score saturation: three holes hit together, repeatedly.
        tick("sat.idle");
        tick("sat.arm");
        for (int k = 0; k < 100; k++) begin
            refresh(32'h0000_0000, "sat.s0");
            refresh(32'h0000_0011, "sat.s1");
            refresh(32'h0000_0022, "sat.s2");
            hit_btn = 16'h0007;
            tick("sat.hit");
            hit_btn = '0;
            tick("sat.rel");
        end
        check("sat.score", 32'(score), 32'(SAT_SCORE));

        // Miss saturation: all 16 buttons on empty holes.
        for (int k = 0; k < 17; k++) begin
            hit_btn = '1;
            tick("msat.press");
            hit_btn = '0;
            tick("msat.rel");
        end
        check("msat.miss", 32'(miss_cnt), 32'd255);

        // Random play.
        new_game("rnd");
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 249) == 0);
            gamestart  = ($urandom_range(0, 39) != 0);
            refreshSig = ($urandom_range(0, 2) == 0);
            randout    = $urandom;
            hit_btn    = hit_btn ^ N'($urandom & $urandom & $urandom);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
